// File: rtl/drec_multitrack_ctrl.sv
// Multi-track sample recorder/player: paces ADC/DAC off a divided tick
// and maps TRACKS address regions onto the SDRAM host FIFOs.
module drec_multitrack_ctrl #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int TRACKS     = 4,
  parameter int SAMPLE_DIV = 25,
  localparam int TB    = $clog2(TRACKS),
  localparam int OFF_W = ADDR_WIDTH - TB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctl_play,
  input  logic                  ctl_rec,
  input  logic                  ctl_stop,
  input  logic [TB-1:0]         ctl_track,
  input  logic                  ctl_loop,
  output logic                  ctl_ack,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  adc_enable,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_enable,
  output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
  output logic [DATA_WIDTH-1:0] sdram_wr_data,
  output logic                  sdram_wr_enable,
  output logic [ADDR_WIDTH-1:0] sdram_rd_addr,
  output logic                  sdram_rd_enable,
  input  logic [DATA_WIDTH-1:0] sdram_rd_data,
  input  logic                  sdram_rd_data_rdy,
  output logic                  sdram_rd_data_ack,
  output logic [7:0]            display
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CMAX = CW'(SAMPLE_DIV - 1);
  localparam logic [OFF_W-1:0] FULL_AT = {OFF_W{1'b1}} - OFF_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [OFF_W-1:0] offset, offset_n, len_cur, len_val;
  logic [OFF_W-1:0] lengths [TRACKS];
  logic [TB-1:0] track, track_n;
  logic underrun, underrun_n, pending, pending_n;
  logic tick, stop_acc, start_acc, go, pend_eff, len_we;
  logic rec_tick, under_tick, play_tick;
  logic ack_n, adc_en_n, wr_en_n, rd_en_n, dac_en_n, rd_ack_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n, rd_addr_n;
  logic [DATA_WIDTH-1:0] wr_data_n, dac_data_n;

  assign tick      = (cnt == CMAX);
  assign len_cur   = lengths[track];
  assign stop_acc  = ctl_stop;
  assign start_acc = !ctl_stop && (ctl_rec || ctl_play)
                     && (state == IDLE) && !pending;
  assign go        = tick && !stop_acc && !start_acc;
  // a word landing on the tick edge still counts as on time
  assign pend_eff   = pending && !sdram_rd_data_rdy;
  assign rec_tick   = go && (state == REC);
  assign under_tick = go && (state == PLAY) && pend_eff;
  assign play_tick  = go && (state == PLAY) && !pend_eff;

  assign display = {state[0], state[1], underrun, 1'b0,
                    offset[OFF_W-1 -: 4]};

  always_comb begin
    state_n    = state;
    offset_n   = offset;
    track_n    = track;
    underrun_n = underrun;
    pending_n  = pending;
    len_we     = 1'b0;
    len_val    = offset;
    ack_n      = ctl_play | ctl_rec | ctl_stop;
    adc_en_n   = 1'b0;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    dac_en_n   = 1'b0;
    rd_ack_n   = 1'b0;
    wr_addr_n  = sdram_wr_addr;
    wr_data_n  = sdram_wr_data;
    rd_addr_n  = sdram_rd_addr;
    dac_data_n = dac_data;
    if (sdram_rd_data_rdy) begin
      rd_ack_n  = 1'b1;
      pending_n = 1'b0;
      if (pending && state == PLAY && !stop_acc) begin
        dac_en_n   = 1'b1;
        dac_data_n = sdram_rd_data;
      end
    end
    unique case (1'b1)
      stop_acc: begin
        if (state == REC) len_we = 1'b1;
        state_n    = IDLE;
        offset_n   = '0;
        underrun_n = 1'b0;
      end
      start_acc: begin
        state_n    = ctl_rec ? REC : PLAY;
        track_n    = ctl_track;
        offset_n   = '0;
        underrun_n = 1'b0;
      end
      rec_tick: begin
        adc_en_n  = 1'b1;
        wr_en_n   = 1'b1;
        wr_data_n = adc_data;
        wr_addr_n = {track, offset};
        offset_n  = offset + 1'b1;
        if (offset == FULL_AT) begin
          state_n = IDLE;
          len_we  = 1'b1;
          len_val = offset + 1'b1;
        end
      end
      under_tick: begin
        underrun_n = 1'b1;
        dac_en_n   = 1'b1;
      end
      play_tick: begin
        if (len_cur == '0) begin
          state_n = IDLE;
        end else if (offset != len_cur) begin
          rd_en_n   = 1'b1;
          rd_addr_n = {track, offset};
          offset_n  = offset + 1'b1;
          pending_n = 1'b1;
        end else if (ctl_loop) begin
          rd_en_n   = 1'b1;
          rd_addr_n = {track, {OFF_W{1'b0}}};
          offset_n  = OFF_W'(1);
          pending_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      offset            <= '0;
      track             <= '0;
      underrun          <= 1'b0;
      pending           <= 1'b0;
      for (int i = 0; i < TRACKS; i++) lengths[i] <= '0;
      ctl_ack           <= 1'b0;
      adc_enable        <= 1'b0;
      dac_enable        <= 1'b0;
      dac_data          <= '0;
      sdram_wr_enable   <= 1'b0;
      sdram_wr_addr     <= '0;
      sdram_wr_data     <= '0;
      sdram_rd_enable   <= 1'b0;
      sdram_rd_addr     <= '0;
      sdram_rd_data_ack <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= tick ? '0 : cnt + 1'b1;
      offset            <= offset_n;
      track             <= track_n;
      underrun          <= underrun_n;
      pending           <= pending_n;
      if (len_we) lengths[track] <= len_val;
      ctl_ack           <= ack_n;
      adc_enable        <= adc_en_n;
      dac_enable        <= dac_en_n;
      dac_data          <= dac_data_n;
      sdram_wr_enable   <= wr_en_n;
      sdram_wr_addr     <= wr_addr_n;
      sdram_wr_data     <= wr_data_n;
      sdram_rd_enable   <= rd_en_n;
      sdram_rd_addr     <= rd_addr_n;
      sdram_rd_data_ack <= rd_ack_n;
    end
  end
endmodule

// File: tb/tb_drec_multitrack_ctrl.sv
// Directed bench for drec_multitrack_ctrl: a 24-bit build and a
// small 6-bit (4-bit offset) build for the region-full case.
module tb_drec_multitrack_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ctl_play, ctl_rec, ctl_stop, ctl_loop, ctl_ack;
  logic [1:0] ctl_track;
  logic [15:0] adc_data, dac_data, wr_data, rd_data;
  logic adc_enable, dac_enable, wr_en, rd_en, rd_rdy, rd_ack;
  logic [23:0] wr_addr, rd_addr;
  logic [7:0] display;

  logic play2, rec2, stop2, loop2, ack2;
  logic [1:0] track2;
  logic adc_en2, dac_en2, wr_en2, rd_en2, rdy2, rd_ack2;
  logic [15:0] dac_data2, wr_data2, rd_data2;
  logic [5:0] wr_addr2, rd_addr2;
  logic [7:0] display2;

  logic hold;
  int checks = 0;
  int failures = 0;

  drec_multitrack_ctrl #(
    .ADDR_WIDTH(24), .DATA_WIDTH(16), .TRACKS(4), .SAMPLE_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_play(ctl_play), .ctl_rec(ctl_rec), .ctl_stop(ctl_stop),
    .ctl_track(ctl_track), .ctl_loop(ctl_loop), .ctl_ack(ctl_ack),
    .adc_data(adc_data), .adc_enable(adc_enable),
    .dac_data(dac_data), .dac_enable(dac_enable),
    .sdram_wr_addr(wr_addr), .sdram_wr_data(wr_data),
    .sdram_wr_enable(wr_en),
    .sdram_rd_addr(rd_addr), .sdram_rd_enable(rd_en),
    .sdram_rd_data(rd_data), .sdram_rd_data_rdy(rd_rdy),
    .sdram_rd_data_ack(rd_ack), .display(display)
  );

  drec_multitrack_ctrl #(
    .ADDR_WIDTH(6), .DATA_WIDTH(16), .TRACKS(4), .SAMPLE_DIV(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .ctl_play(play2), .ctl_rec(rec2), .ctl_stop(stop2),
    .ctl_track(track2), .ctl_loop(loop2), .ctl_ack(ack2),
    .adc_data(adc_data), .adc_enable(adc_en2),
    .dac_data(dac_data2), .dac_enable(dac_en2),
    .sdram_wr_addr(wr_addr2), .sdram_wr_data(wr_data2),
    .sdram_wr_enable(wr_en2),
    .sdram_rd_addr(rd_addr2), .sdram_rd_enable(rd_en2),
    .sdram_rd_data(rd_data2), .sdram_rd_data_rdy(rdy2),
    .sdram_rd_data_ack(rd_ack2), .display(display2)
  );

  int n_wr = 0, n_rd = 0, n_dac = 0, n_ack = 0, n_rdack = 0;
  int n_wr2 = 0, n_rd2 = 0, n_dac2 = 0;
  logic [23:0] wr_log[$];
  logic [23:0] rd_log[$];
  logic [15:0] dac_log[$];
  logic [15:0] wdat_log[$];
  logic [5:0] last_wr2 = '0;

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      n_wr++;
      wr_log.push_back(wr_addr);
      wdat_log.push_back(wr_data);
    end
    if (rd_en) begin
      n_rd++;
      rd_log.push_back(rd_addr);
    end
    if (dac_enable) begin
      n_dac++;
      dac_log.push_back(dac_data);
    end
    if (ctl_ack) n_ack++;
    if (rd_ack) n_rdack++;
    if (wr_en2) begin
      n_wr2++;
      last_wr2 = wr_addr2;
    end
    if (rd_en2) n_rd2++;
    if (dac_en2) n_dac2++;
  end

  // read-data FIFO model: word ready two cycles after each request
  initial begin
    int cd;
    logic [15:0] nd;
    cd = 0;
    nd = '0;
    rd_rdy = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_rdy = 1'b0;
      if (cd > 0) begin
        if (cd > 1 || !hold) cd--;
        if (cd == 0) begin
          rd_rdy = 1'b1;
          rd_data = nd;
        end
      end
      if (rd_en) begin
        cd = 2;
        nd = 16'h1000 + 16'(rd_addr[11:0]);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic r, input logic p, input logic s,
                     input logic [1:0] t);
    ctl_rec = r;
    ctl_play = p;
    ctl_stop = s;
    ctl_track = t;
    @(negedge clk);
    ctl_rec = 1'b0;
    ctl_play = 1'b0;
    ctl_stop = 1'b0;
  endtask

  initial begin
    int a0, b_rd, b_dac, b_rdack;
    rst_n = 1'b0;
    ctl_play = 0; ctl_rec = 0; ctl_stop = 0; ctl_loop = 0;
    ctl_track = '0;
    play2 = 0; rec2 = 0; stop2 = 0; loop2 = 0; track2 = '0;
    rdy2 = 0; rd_data2 = '0;
    adc_data = 16'hBEEF;
    hold = 1'b0;
    cyc(3);
    chk("rst_strobes", {ctl_ack, adc_enable, dac_enable, wr_en,
                        rd_en, rd_ack}, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_wr", {wr_addr, wr_data}, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_display", display, 0);
    rst_n = 1'b1;
    cyc(2);

    cmd(1, 0, 0, 2);
    chk("rec_state", display[7:6], 2'b10);
    for (int i = 0; i < 200 && n_wr < 10; i++) @(negedge clk);
    cmd(0, 0, 1, 0);
    cyc(3);
    chk("rec_writes", n_wr, 10);
    chk("rec_idle", display[7:6], 2'b00);
    chk("rec_acks", n_ack, 2);
    for (int i = 0; i < 10; i++)
      chk("rec_addr", wr_log[i], 24'h800000 + 24'(i));
    chk("rec_data", wdat_log[9], 16'hBEEF);

    b_rd = n_rd;
    b_dac = n_dac;
    cmd(0, 1, 0, 2);
    for (int i = 0; i < 300 && display[6]; i++) @(negedge clk);
    chk("play_idle", display[6], 0);
    cyc(2);
    chk("play_reads", n_rd - b_rd, 10);
    chk("play_dacs", n_dac - b_dac, 10);
    for (int i = 0; i < 10; i++) begin
      chk("play_addr", rd_log[b_rd + i], 24'h800000 + 24'(i));
      chk("play_dac_data", dac_log[b_dac + i], 16'h1000 + 16'(i));
    end
    chk("play_underrun", display[5], 0);

    b_rd = n_rd;
    b_dac = n_dac;
    b_rdack = n_rdack;
    ctl_loop = 1'b1;
    cmd(0, 1, 0, 2);
    for (int i = 0; i < 300 && (n_rd - b_rd) < 11; i++) @(negedge clk);
    chk("loop_reads", n_rd - b_rd, 11);
    chk("loop_wrap_addr", rd_log[b_rd + 10], 24'h800000);
    cmd(0, 0, 1, 0);
    ctl_loop = 1'b0;
    cyc(6);
    chk("loop_stop_idle", display[7:6], 2'b00);
    chk("loop_dacs", n_dac - b_dac, 10);
    chk("loop_pops", n_rdack - b_rdack, 11);

    hold = 1'b1;
    b_rd = n_rd;
    b_dac = n_dac;
    cmd(0, 1, 0, 2);
    for (int i = 0; i < 50 && !display[5]; i++) @(negedge clk);
    chk("underrun_set", display[5], 1);
    chk("underrun_dacs", n_dac - b_dac, 1);
    chk("underrun_repeat", dac_log[b_dac], 16'h1009);
    hold = 1'b0;
    for (int i = 0; i < 400 && display[6]; i++) @(negedge clk);
    chk("underrun_reads", n_rd - b_rd, 10);
    chk("underrun_sticky", display, 8'h20);
    cmd(0, 1, 0, 2);
    chk("underrun_cleared", display[6:5], 2'b10);
    cmd(0, 0, 1, 0);
    cyc(4);

    cmd(1, 0, 0, 1);
    cyc(6);
    a0 = n_ack;
    cmd(0, 1, 0, 3);
    cyc(2);
    chk("ignored_play_ack", n_ack - a0, 1);
    chk("ignored_play_state", display[7:6], 2'b10);
    a0 = n_ack;
    cmd(1, 1, 1, 3);
    cyc(2);
    chk("triple_ack", n_ack - a0, 1);
    chk("triple_stop", display[7:6], 2'b00);

    cmd(0, 1, 0, 2);
    cyc(7);
    chk("mid_play", display[6], 1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobes", {ctl_ack, adc_enable, dac_enable, wr_en,
                         rd_en, rd_ack}, 0);
    chk("arst_addr", {wr_addr, rd_addr}, 0);
    chk("arst_data", {wr_data, dac_data}, 0);
    chk("arst_display", display, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    b_rd = n_rd;
    b_dac = n_dac;
    cmd(0, 1, 0, 2);
    for (int i = 0; i < 20 && display[6]; i++) @(negedge clk);
    chk("empty_idle", display[6], 0);
    cyc(2);
    chk("empty_reads", n_rd - b_rd, 0);
    chk("empty_dacs", n_dac - b_dac, 0);

    rec2 = 1'b1;
    track2 = 2'd3;
    @(negedge clk);
    rec2 = 1'b0;
    for (int i = 0; i < 200 && display2[7]; i++) @(negedge clk);
    cyc(1);
    chk("full_writes", n_wr2, 14);
    chk("full_last_addr", last_wr2, 6'h3D);
    chk("full_display", display2, 8'h0E);
    rdy2 = 1'b1;
    play2 = 1'b1;
    @(negedge clk);
    play2 = 1'b0;
    for (int i = 0; i < 200 && display2[6]; i++) @(negedge clk);
    cyc(2);
    chk("full_play_reads", n_rd2, 14);
    chk("full_play_dacs", n_dac2, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
